// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter.
// Source ids, register address width and the buffered result entry.
package wb_pkg;

  typedef enum logic [1:0] {
    WB_NONE,
    WB_ALU,
    WB_LSU
  } wb_src_e;

  localparam int REG_AW  = 5;
  localparam int WB_XLEN = 32;

  typedef struct packed {
    logic [REG_AW-1:0]  rd;
    logic [WB_XLEN-1:0] data;
  } wb_entry_t;

endpackage

// File: rtl/wb_slot.sv
// One-entry result buffer with valid/ready.
// Writes to x0 are accepted but never stored.
module wb_slot
  import wb_pkg::*;
#(
  parameter type entry_t = wb_entry_t
) (
  input  logic   clk,
  input  logic   rst_n,
  input  logic   valid_i,
  input  entry_t entry_i,
  input  logic   take_i,
  output logic   ready_o,
  output logic   full_o,
  output logic   fill_o,
  output entry_t entry_o
);

  logic   full_q, full_d;
  entry_t entry_q, entry_d;

  assign ready_o = rst_n && (!full_q || take_i);
  assign fill_o  = valid_i && ready_o && (entry_i.rd != '0);
  assign full_o  = full_q;
  assign entry_o = entry_q;

  always_comb begin
    full_d  = full_q;
    entry_d = entry_q;
    if (fill_o) begin
      full_d  = 1'b1;
      entry_d = entry_i;
    end else if (take_i) begin
      full_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q  <= 1'b0;
      entry_q <= '0;
    end else begin
      full_q  <= full_d;
      entry_q <= entry_d;
    end
  end

endmodule

// File: rtl/wb_arbiter.sv
// Writeback arbiter: serialises ALU and LSU results onto the
// single regfile write port with LSU priority and starvation guard.
module wb_arbiter
  import wb_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [REG_AW-1:0] alu_rd,
  input  logic [XLEN-1:0]   alu_data,
  input  logic              lsu_valid,
  output logic              lsu_ready,
  input  logic [REG_AW-1:0] lsu_rd,
  input  logic [XLEN-1:0]   lsu_data,
  output logic              rf_we,
  output logic [REG_AW-1:0] rf_wa,
  output logic [XLEN-1:0]   rf_wd,
  output logic              busy
);

  typedef struct packed {
    logic [REG_AW-1:0] rd;
    logic [XLEN-1:0]   data;
  } entry_t;

  localparam logic [3:0] SMAX = 4'(STARVE_MAX);

  entry_t  alu_e, lsu_e;
  logic    alu_full, lsu_full;
  logic    alu_fill, lsu_fill;
  wb_src_e grant;

  logic              rf_we_q, rf_we_d;
  logic [REG_AW-1:0] rf_wa_q, rf_wa_d;
  logic [XLEN-1:0]   rf_wd_q, rf_wd_d;
  logic [3:0]        streak_q, streak_d;
  logic              lsu_old_q, lsu_old_d;

  wb_slot #(.entry_t(entry_t)) u_alu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (alu_valid),
    .entry_i ('{rd: alu_rd, data: alu_data}),
    .take_i  (grant == WB_ALU),
    .ready_o (alu_ready),
    .full_o  (alu_full),
    .fill_o  (alu_fill),
    .entry_o (alu_e)
  );

  wb_slot #(.entry_t(entry_t)) u_lsu_slot (
    .clk     (clk),
    .rst_n   (rst_n),
    .valid_i (lsu_valid),
    .entry_i ('{rd: lsu_rd, data: lsu_data}),
    .take_i  (grant == WB_LSU),
    .ready_o (lsu_ready),
    .full_o  (lsu_full),
    .fill_o  (lsu_fill),
    .entry_o (lsu_e)
  );

  // Same destination: older slot first so the younger value lands last.
  always_comb begin
    grant = WB_NONE;
    if (alu_full && !lsu_full)
      grant = WB_ALU;
    else if (lsu_full && !alu_full)
      grant = WB_LSU;
    else if (alu_full && lsu_full) begin
      if (alu_e.rd == lsu_e.rd)
        grant = lsu_old_q ? WB_LSU : WB_ALU;
      else if (streak_q == SMAX)
        grant = WB_ALU;
      else
        grant = WB_LSU;
    end
  end

  always_comb begin
    rf_we_d  = 1'b0;
    rf_wa_d  = rf_wa_q;
    rf_wd_d  = rf_wd_q;
    streak_d = streak_q;
    unique case (1'b1)
      grant == WB_ALU: begin
        rf_we_d = 1'b1;
        rf_wa_d = alu_e.rd;
        rf_wd_d = alu_e.data;
      end
      grant == WB_LSU: begin
        rf_we_d = 1'b1;
        rf_wa_d = lsu_e.rd;
        rf_wd_d = lsu_e.data;
      end
      default: ;
    endcase
    if (!alu_full || grant == WB_ALU)
      streak_d = '0;
    else if (grant == WB_LSU && streak_q != SMAX)
      streak_d = streak_q + 4'd1;
  end

  always_comb begin
    lsu_old_d = lsu_old_q;
    if (alu_fill && lsu_fill)
      lsu_old_d = 1'b1;
    else if (lsu_fill)
      lsu_old_d = 1'b0;
    else if (alu_fill)
      lsu_old_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      rf_we_q   <= 1'b0;
      rf_wa_q   <= '0;
      rf_wd_q   <= '0;
      streak_q  <= '0;
      lsu_old_q <= 1'b1;
    end else begin
      rf_we_q   <= rf_we_d;
      rf_wa_q   <= rf_wa_d;
      rf_wd_q   <= rf_wd_d;
      streak_q  <= streak_d;
      lsu_old_q <= lsu_old_d;
    end
  end

  assign rf_we = rf_we_q;
  assign rf_wa = rf_wa_q;
  assign rf_wd = rf_wd_q;
  assign busy  = alu_full || lsu_full || rf_we_q;

endmodule
